// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the lsu_mem_stage load/store unit.
// Holds the RV32 funct3 encodings, the FSM state type, the memory write-enable
// encodings and small request-classification helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    localparam logic [1:0] MEM_WE_NONE = 2'b00;
    localparam logic [1:0] MEM_WE_WORD = 2'b01;

    // True for the five funct3 codes a load/store may carry.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
               (f3 == LSU_BU) || (f3 == LSU_HU);
    endfunction

    // True when the byte address is not naturally aligned for the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: request/response handshake and word-memory bus of the LSU.
// master = execute stage plus memory model side, slave = the LSU itself.
interface lsu_mem_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [1:0]            mem_we;
    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane out of a memory word and
// sign- or zero-extends it according to the load funct3. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            addr,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    // Lane select followed by the extension chosen by funct3.
    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? word[31:16] : word[15:0];
        case (funct3)
            LSU_B:   data = DATA_WIDTH'(lane_b);
            LSU_BU:  data = DATA_WIDTH'($unsigned(lane_b));
            LSU_H:   data = DATA_WIDTH'(lane_h);
            LSU_HU:  data = DATA_WIDTH'($unsigned(lane_h));
            LSU_W:   data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32 load/store unit between execute and a word-organised
// data memory. One request per handshake, one registered response per request.
// Sub-word stores are done as read-modify-write so memory only sees word writes.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses answer with
// rsp_err instead of being forced to natural alignment.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 18
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_stage_if.slave bus
);

    localparam int AW = MEM_ADDR_WIDTH + 2;

    lsu_state_e            state;
    lsu_state_e            state_next;

    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_bad;
    logic [AW-1:0]         addr_in;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    // Address bits above the memory window never reach the memory.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[DATA_WIDTH-1:AW];

    // Classify the incoming request and force its address to natural alignment.
    always_comb begin
        addr_in = bus.req_addr[AW-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = !funct3_legal(bus.req_funct3) ||
                  is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
        req_bad = !funct3_legal(bus.req_funct3);
`endif
        if (bus.req_funct3[1:0] == 2'b01) begin
            addr_in[0] = 1'b0;
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            addr_in[1:0] = 2'b00;
        end
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .word  (bus.mem_rd),
        .addr  (addr_q[1:0]),
        .funct3(funct3_q),
        .data  (load_data)
    );

    // Replace the addressed byte/half lane of the old word with the store data.
    always_comb begin
        merged = old_q;
        if (funct3_q[0]) begin
            if (addr_q[1]) begin
                merged[DATA_WIDTH-1:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus handshake and memory-write outputs; only a W store in
    // ACCESS or any store in WRITE may raise mem_we.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.mem_we    = MEM_WE_NONE;
        bus.mem_wd    = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    state_next = RESP;
                end else if (funct3_q == LSU_W) begin
                    bus.mem_we = MEM_WE_WORD;
                    bus.mem_wd = wdata_q;
                    state_next = RESP;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.mem_we = MEM_WE_WORD;
                bus.mem_wd = merged;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, load result / old-word latching, response clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= addr_in;
                        wdata_q  <= bus.req_wdata;
                        funct3_q <= bus.req_funct3;
                        we_q     <= bus.req_we;
                        err_q    <= req_bad;
                        rdata_q  <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                    end else begin
                        old_q <= bus.mem_rd;
                    end
                end
                RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_a     = {{(DATA_WIDTH-MEM_ADDR_WIDTH){1'b0}}, addr_q[AW-1:2]};
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized bench for lsu_mem_stage with a
// transaction-level reference model and a 32-word memory model.
module tb_lsu_mem_stage;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 18;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    lsu_mem_stage_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    lsu_mem_stage #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h8899AABB;
        if (i == 17) return 32'h01234567;
        return 32'(i + 1) * 32'h9E3779B9;
    endfunction

    // Memory the DUT talks to.
    logic [31:0] tb_mem [32];
    assign bus.mem_rd = tb_mem[bus.mem_a[4:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_we == 2'b01) begin
            tb_mem[bus.mem_a[4:0]] <= bus.mem_wd;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [32];
    bit          busy, ready_prev, has_wr, pend_wr, e_err;
    int          k, lat, wr_k, txn_count;
    logic [31:0] e_rdata, wr_data;
    logic [17:0] e_idx;

    int          checks, failures;
    int          obs_lat, obs_wk;
    logic [31:0] obs_rdata, obs_wd, obs_wa;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    // Compute what the accepted request must produce.
    task automatic model_start();
        logic [2:0]  f3;
        logic [31:0] a, ea, wd, word, b, h, mask;
        bit          ill;
        int          sh;
        f3  = bus.req_funct3;
        a   = bus.req_addr;
        wd  = bus.req_wdata;
        ea  = a;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        e_err = ill || (((f3 == 3'b001) || (f3 == 3'b101)) && a[0]) ||
                ((f3 == 3'b010) && (a[1:0] != 2'b00));
`else
        e_err = ill;
        if ((f3 == 3'b001) || (f3 == 3'b101)) ea[0] = 1'b0;
        if (f3 == 3'b010) ea[1:0] = 2'b00;
`endif
        busy    = 1'b1;
        k       = 1;
        has_wr  = 1'b0;
        wr_k    = 0;
        e_rdata = 32'h0;
        e_idx   = ea[19:2];
        if (e_err) begin
            lat = 1;
        end else begin
            word = ref_mem[e_idx[4:0]];
            sh   = 8 * int'(ea[1:0]);
            if (!bus.req_we) begin
                lat = 2;
                b = (word >> sh) & 32'hFF;
                h = (word >> sh) & 32'hFFFF;
                case (f3)
                    3'b000:  e_rdata = (b >= 128)   ? (b | 32'hFFFFFF00) : b;
                    3'b100:  e_rdata = b;
                    3'b001:  e_rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'b101:  e_rdata = h;
                    default: e_rdata = word;
                endcase
            end else if (f3 == 3'b010) begin
                lat = 2; wr_k = 1; has_wr = 1'b1; wr_data = wd;
            end else begin
                lat  = 3; wr_k = 2; has_wr = 1'b1;
                mask = (f3[0] ? 32'hFFFF : 32'hFF) << sh;
                wr_data = (word & ~mask) | ((wd << sh) & mask);
            end
        end
        pend_wr = has_wr;
    endtask

    // Once per cycle at the falling edge: advance the model, then compare.
    task automatic step();
        bit exp_v, exp_w;
        if (rst) begin
            busy = 1'b0; pend_wr = 1'b0; ready_prev = 1'b1;
            if (mem_init) for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
            return;
        end
        if (busy) begin
            k++;
            if (pend_wr && k == wr_k + 1) begin
                ref_mem[e_idx[4:0]] = wr_data;
                pend_wr = 1'b0;
            end
            if (k > lat) busy = 1'b0;
        end
        if (bus.req_valid && ready_prev) begin
            model_start();
            txn_count++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(!busy));
        exp_v = busy && (k == lat);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_rdata", bus.rsp_rdata, e_rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        end
        if (bus.rsp_valid) begin
            obs_lat = busy ? k : 99; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
        end
        exp_w = busy && has_wr && (k == wr_k);
        chk("mem_we", 32'(bus.mem_we), exp_w ? 32'h1 : 32'h0);
        if (exp_w || (busy && !e_err && k == 1)) chk("mem_a", bus.mem_a, 32'(e_idx));
        if (exp_w) chk("mem_wd", bus.mem_wd, wr_data);
        if (bus.mem_we == 2'b01) begin
            obs_wk = busy ? k : 99; obs_wd = bus.mem_wd; obs_wa = bus.mem_a;
        end
        ready_prev = !busy;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int start;
        obs_lat = 0; obs_wk = 0; obs_rdata = 32'hX; obs_err = 1'bX; obs_wd = 32'hX; obs_wa = 32'hX;
        start = txn_count;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        for (int i = 0; i < 6 && txn_count == start; i++) tick();
        bus.req_valid = 1'b0;
        if (txn_count == start) chk("xfer_timeout", 32'(txn_count), 32'(start + 1));
        for (int i = 0; i < 8 && busy; i++) tick();
        if (busy) chk("rsp_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        checks = 0; failures = 0; txn_count = 0;
        busy = 1'b0; pend_wr = 1'b0; ready_prev = 1'b1; k = 0; lat = 0;

        repeat (3) tick();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);
        mem_init = 1'b0;
        rst = 1'b0;
        tick();

        // Loads from word 0x10 = 0x8899AABB.
        do_req(1'b0, 3'b000, 32'h41, 32'h0);
        chk("lb_data", obs_rdata, 32'hFFFFFFAA);
        chk("lb_model", e_rdata, 32'hFFFFFFAA);
        chk("lb_lat", 32'(obs_lat), 32'd2);
        chk("lb_err", 32'(obs_err), 32'h0);
        do_req(1'b0, 3'b100, 32'h41, 32'h0);
        chk("lbu_data", obs_rdata, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h42, 32'h0);
        chk("lh_data", obs_rdata, 32'hFFFF8899);
        chk("lh_model", e_rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h42, 32'h0);
        chk("lhu_data", obs_rdata, 32'h00008899);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        chk("lw_data", obs_rdata, 32'h8899AABB);

        // Sub-word store read-modify-write.
        do_req(1'b1, 3'b000, 32'h43, 32'h12345678);
        chk("sb_wd", obs_wd, 32'h7899AABB);
        chk("sb_model", wr_data, 32'h7899AABB);
        chk("sb_wr_cycle", 32'(obs_wk), 32'd2);
        chk("sb_lat", 32'(obs_lat), 32'd3);
        chk("sb_rdata", obs_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        chk("lw_after_sb", obs_rdata, 32'h7899AABB);

        // Word store.
        do_req(1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
        chk("sw_wr_cycle", 32'(obs_wk), 32'd1);
        chk("sw_mem_a", obs_wa, 32'h11);
        chk("sw_lat", 32'(obs_lat), 32'd2);

        // Misaligned word load.
        do_req(1'b0, 3'b010, 32'h42, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_err", 32'(obs_err), 32'h1);
        chk("lw_mis_lat", 32'(obs_lat), 32'd1);
        chk("lw_mis_nowr", 32'(obs_wk), 32'd0);
`else
        chk("lw_mis_err", 32'(obs_err), 32'h0);
        chk("lw_mis_data", obs_rdata, 32'h7899AABB);
        chk("lw_mis_lat", 32'(obs_lat), 32'd2);
`endif

        // Illegal funct3.
        do_req(1'b0, 3'b011, 32'h40, 32'h0);
        chk("ill_err", 32'(obs_err), 32'h1);
        chk("ill_lat", 32'(obs_lat), 32'd1);

        // Halfword store to upper lane of word 0x11.
        do_req(1'b1, 3'b001, 32'h46, 32'h0000CAFE);
        chk("sh_wd", obs_wd, 32'hCAFEBEEF);

        // Reset while an SB sits in WRITE: no write may reach memory.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h00000055;
        begin
            int start;
            start = txn_count;
            for (int i = 0; i < 6 && txn_count == start; i++) tick();
            if (txn_count == start) chk("rstw_xfer_timeout", 32'(txn_count), 32'(start + 1));
        end
        bus.req_valid = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("rstw_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rstw_mem_wd", bus.mem_wd, 32'h0);
        chk("rstw_mem_a", bus.mem_a, 32'h0);
        chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rstw_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rstw_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rstw_mem_word", tb_mem[16], 32'h7899AABB);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        chk("lw_after_rst", obs_rdata, 32'h7899AABB);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          sel;
            repeat ($urandom_range(0, 2)) tick();
            we  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 15);
            if (we) f3 = (sel < 13) ? 3'(sel % 3) : ((sel == 13) ? 3'b011 : ((sel == 14) ? 3'b110 : 3'b111));
            else    f3 = (sel < 14) ? 3'((sel % 5 < 3) ? sel % 5 : sel % 5 + 1) : ((sel == 14) ? 3'b011 : 3'b111);
            addr = ($urandom & 32'hFFF00000) | 32'($urandom_range(0, 127));
            do_req(we, f3, addr, $urandom);
        end
        tick();
        tick();

        for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), tb_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
